// File: rtl/rd_trigger_conditioner_pkg.sv
// Shared definitions for the radio-detector trigger path: FSM state
// encodings and a width helper used to size the internal counters.
package rd_trigger_conditioner_pkg;

    typedef enum logic [1:0] {
        RD_ST_IDLE    = 2'd0,
        RD_ST_QUALIFY = 2'd1,
        RD_ST_HIGH    = 2'd2,
        RD_ST_HOLDOFF = 2'd3
    } rd_state_e;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int rd_clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/rd_trigger_conditioner_sat_counter.sv
// Saturating event counter with sticky overflow; a clear in the same cycle
// as an increment is applied first so the increment still counts.
module rd_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow
);

    logic [CNT_WIDTH-1:0] count_reg, count_next, count_base;
    logic                 overflow_reg, overflow_next;

    always_comb begin
        count_base    = clr ? '0 : count_reg;
        overflow_next = clr ? 1'b0 : overflow_reg;
        count_next    = count_base;
        if (inc) begin
            if (&count_base) begin
                overflow_next = 1'b1;
            end else begin
                count_next = count_base + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/rd_trigger_conditioner.sv
// Debounces the synchronized detector level, emits one pulse per qualified
// rising edge, enforces a post-trigger holdoff and counts events.
module rd_trigger_conditioner
    import rd_trigger_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 SYNC_IN,
    input  logic                 ENABLE,
    input  logic                 CLR_COUNT,
    output logic                 TRIG_PULSE,
    output logic                 TRIG_LEVEL,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] EVENT_COUNT,
    output logic                 OVERFLOW
);

    localparam int QW = rd_clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = rd_clog2(HOLDOFF_CYCLES + 1);
    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [HW-1:0] H_LOAD = HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    rd_state_e     state_reg, state_next;
    logic [QW-1:0] qcnt_reg, qcnt_next;
    logic [HW-1:0] hcnt_reg, hcnt_next;
    logic          pulse_reg, fire_next;
    logic          level_reg;

    always_comb begin
        state_next = state_reg;
        qcnt_next  = qcnt_reg;
        hcnt_next  = hcnt_reg;
        fire_next  = 1'b0;
        // Disable overrides everything, including an event about to fire.
        if (!ENABLE) begin
            state_next = RD_ST_IDLE;
            qcnt_next  = '0;
            hcnt_next  = '0;
        end else begin
            case (state_reg)
                RD_ST_IDLE: begin
                    if (SYNC_IN) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_next = RD_ST_HIGH;
                            fire_next  = 1'b1;
                        end else begin
                            state_next = RD_ST_QUALIFY;
                            qcnt_next  = Q_ONE;
                        end
                    end
                end
                RD_ST_QUALIFY: begin
                    if (!SYNC_IN) begin
                        state_next = RD_ST_IDLE;
                        qcnt_next  = '0;
                    end else if (qcnt_reg == Q_LAST) begin
                        state_next = RD_ST_HIGH;
                        qcnt_next  = '0;
                        fire_next  = 1'b1;
                    end else begin
                        qcnt_next = qcnt_reg + Q_ONE;
                    end
                end
                RD_ST_HIGH: begin
                    if (!SYNC_IN) begin
                        if (HOLDOFF_CYCLES > 0) begin
                            state_next = RD_ST_HOLDOFF;
                            hcnt_next  = H_LOAD;
                        end else begin
                            state_next = RD_ST_IDLE;
                        end
                    end
                end
                RD_ST_HOLDOFF: begin
                    if (hcnt_reg == '0) begin
                        state_next = RD_ST_IDLE;
                    end else begin
                        hcnt_next = hcnt_reg - H_ONE;
                    end
                end
                default: begin
                    state_next = RD_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= RD_ST_IDLE;
            qcnt_reg  <= '0;
            hcnt_reg  <= '0;
            pulse_reg <= 1'b0;
            level_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            qcnt_reg  <= qcnt_next;
            hcnt_reg  <= hcnt_next;
            pulse_reg <= fire_next;
            level_reg <= (state_next == RD_ST_HIGH);
        end
    end

    rd_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_event_counter (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .inc      (fire_next),
        .clr      (CLR_COUNT),
        .count    (EVENT_COUNT),
        .overflow (OVERFLOW)
    );

    assign TRIG_PULSE = pulse_reg;
    assign TRIG_LEVEL = level_reg;
    assign BUSY       = (state_reg != RD_ST_IDLE);

endmodule
